// File: rtl/fpu_norm_shift_if.sv
// Valid/ready bundle between the adder/LZA, the normalization stage and the rounder.
// The slave modport is the normalization stage's view; master is the surrounding logic's.
interface fpu_norm_shift_if #(
    parameter int EXP_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [47:0]      in_sum;
    logic [5:0]       in_lza_count;
    logic [EXP_W-1:0] in_exp;
    logic             in_sign;

    logic             out_valid;
    logic             out_ready;
    logic [47:0]      out_mant;
    logic [EXP_W-1:0] out_exp;
    logic             out_sign;
    logic             out_zero;
    logic             out_subnormal;
    logic             out_lza_corr;

    modport slave (
        input  in_valid, in_sum, in_lza_count, in_exp, in_sign, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_sign, out_zero,
               out_subnormal, out_lza_corr
    );

    modport master (
        output in_valid, in_sum, in_lza_count, in_exp, in_sign, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_sign, out_zero,
               out_subnormal, out_lza_corr
    );
endinterface

// File: rtl/fpu_norm_shift.sv
// FP add/sub normalization: LZA-driven left shift, 1-bit LZA correction, exponent clamp.
// Optional saturating LZA-correction counter enabled by macro FPU_NORM_CORR_CNT_EN.
module fpu_norm_shift #(
    parameter int EXP_W = 10,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fpu_norm_shift_if.slave   bus
`ifdef FPU_NORM_CORR_CNT_EN
    ,
    output logic [CNT_W-1:0]  corr_count
`endif
);

    if (EXP_W < 6 || CNT_W < 1) begin : g_param_check
        $error("fpu_norm_shift: EXP_W must be >= 6 and CNT_W >= 1");
    end

    function automatic logic [5:0] clamp_cnt(input logic [5:0] c);
        return (c > 6'd47) ? 6'd47 : c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             vld_p1_q, vld_p2_q;
    logic             adv_p2, acc_p1;

    logic [5:0]       cnt_s1;
    logic [EXP_W-1:0] lim_s1;
    logic [47:0]      mant_p1_d, mant_p1_q;
    logic [5:0]       sh_p1_d, sh_p1_q;
    logic             lim_p1_d, lim_p1_q;
    logic             zero_p1_d, zero_p1_q;
    logic [EXP_W-1:0] exp_p1_q;
    logic             sign_p1_q;

    logic [47:0]      mant_p2_d, mant_p2_q;
    logic [EXP_W-1:0] exp_p2_d, exp_p2_q;
    logic [EXP_W-1:0] tot_s2;
    logic             corr_p2_d, corr_p2_q;
    logic             sub_p2_d, sub_p2_q;
    logic             zero_p2_q, sign_p2_q;

    assign adv_p2       = !vld_p2_q || bus.out_ready;
    assign bus.in_ready = !vld_p1_q || adv_p2;
    assign acc_p1       = bus.in_valid && bus.in_ready;

    // Stage 1: shift limited by both the LZA count and the subnormal boundary
    always_comb begin
        cnt_s1    = clamp_cnt(bus.in_lza_count);
        lim_s1    = (bus.in_exp == '0) ? '0 : bus.in_exp - EXP_W'(1);
        lim_p1_d  = (EXP_W'(cnt_s1) >= lim_s1);
        sh_p1_d   = lim_p1_d ? lim_s1[5:0] : cnt_s1;
        mant_p1_d = bus.in_sum << sh_p1_d;
        zero_p1_d = (bus.in_sum == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            mant_p1_q <= '0;
            sh_p1_q   <= '0;
            lim_p1_q  <= 1'b0;
            zero_p1_q <= 1'b0;
            exp_p1_q  <= '0;
            sign_p1_q <= 1'b0;
        end else begin
            if (bus.in_ready) vld_p1_q <= bus.in_valid;
            if (acc_p1) begin
                mant_p1_q <= mant_p1_d;
                sh_p1_q   <= sh_p1_d;
                lim_p1_q  <= lim_p1_d;
                zero_p1_q <= zero_p1_d;
                exp_p1_q  <= bus.in_exp;
                sign_p1_q <= bus.in_sign;
            end
        end
    end

    // Stage 2: the extra shift is only allowed while below the exponent limit
    always_comb begin
        corr_p2_d = !zero_p1_q && !mant_p1_q[47] && !lim_p1_q;
        mant_p2_d = corr_p2_d ? {mant_p1_q[46:0], 1'b0} : mant_p1_q;
        sub_p2_d  = !zero_p1_q && !mant_p2_d[47];
        tot_s2    = EXP_W'(sh_p1_q) + EXP_W'(corr_p2_d);
        exp_p2_d  = (zero_p1_q || sub_p2_d) ? '0 : exp_p1_q - tot_s2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2_q  <= 1'b0;
            mant_p2_q <= '0;
            exp_p2_q  <= '0;
            corr_p2_q <= 1'b0;
            sub_p2_q  <= 1'b0;
            zero_p2_q <= 1'b0;
            sign_p2_q <= 1'b0;
        end else if (adv_p2) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                mant_p2_q <= mant_p2_d;
                exp_p2_q  <= exp_p2_d;
                corr_p2_q <= corr_p2_d;
                sub_p2_q  <= sub_p2_d;
                zero_p2_q <= zero_p1_q;
                sign_p2_q <= sign_p1_q;
            end
        end
    end

    assign bus.out_valid     = vld_p2_q;
    assign bus.out_mant      = mant_p2_q;
    assign bus.out_exp       = exp_p2_q;
    assign bus.out_sign      = sign_p2_q;
    assign bus.out_zero      = zero_p2_q;
    assign bus.out_subnormal = sub_p2_q;
    assign bus.out_lza_corr  = corr_p2_q;

`ifdef FPU_NORM_CORR_CNT_EN
    logic [CNT_W-1:0] corr_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            corr_cnt_q <= '0;
        end else if (vld_p2_q && bus.out_ready && corr_p2_q) begin
            corr_cnt_q <= sat_inc(corr_cnt_q);
        end
    end

    assign corr_count = corr_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_norm_shift.sv
// Scoreboard bench for fpu_norm_shift: directed vectors, stall and mid-flight reset.
module tb_fpu_norm_shift;
    localparam int EXP_W = 10;

    typedef struct {
        logic [47:0] sum;
        logic [5:0]  cnt;
        logic [9:0]  exp;
        logic        sign;
        logic [47:0] mant;
        logic [9:0]  oexp;
        logic        zero;
        logic        sub;
        logic        corr;
    } vec_t;

    typedef struct {
        vec_t v;
        bit   chk_lat;
        int   acc_cyc;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_norm_shift_if #(.EXP_W(EXP_W)) bus ();
`ifdef FPU_NORM_CORR_CNT_EN
    logic [15:0] corr_count;
`endif

    fpu_norm_shift #(.EXP_W(EXP_W), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FPU_NORM_CORR_CNT_EN
        ,
        .corr_count (corr_count)
`endif
    );

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   exp_cc = 0;
    sb_t  sb[$];
    vec_t tv[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic send(input vec_t v, input bit lat, input bit expect_block);
        int w;
        @(negedge clk);
        bus.in_valid     = 1'b1;
        bus.in_sum       = v.sum;
        bus.in_lza_count = v.cnt;
        bus.in_exp       = v.exp;
        bus.in_sign      = v.sign;
        #1;
        if (expect_block) chk("in_ready_when_full", {63'd0, bus.in_ready}, 64'd0);
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
        end else begin
            sb.push_back('{v: v, chk_lat: lat, acc_cyc: cyc});
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            #2;
            w++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d items outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        #2;
    endtask

    // Monitor: compares every output transfer and checks hold while stalled
    initial begin
        logic [61:0] held, cur;
        bit          held_v;
        sb_t         e;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            #1;
            cur = {bus.out_mant, bus.out_exp, bus.out_sign, bus.out_zero,
                   bus.out_subnormal, bus.out_lza_corr};
            if (!rst_n || !bus.out_valid) begin
                held_v = 1'b0;
            end else begin
                if (held_v) chk("stall_hold", {2'd0, cur}, {2'd0, held});
                if (bus.out_ready) begin
                    held_v = 1'b0;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_output: mant=%0h exp=%0d with empty scoreboard",
                                 bus.out_mant, bus.out_exp);
                    end else begin
                        e = sb.pop_front();
                        chk("out_mant", {16'd0, bus.out_mant}, {16'd0, e.v.mant});
                        chk("out_exp", {54'd0, bus.out_exp}, {54'd0, e.v.oexp});
                        chk("out_sign", {63'd0, bus.out_sign}, {63'd0, e.v.sign});
                        chk("out_zero", {63'd0, bus.out_zero}, {63'd0, e.v.zero});
                        chk("out_subnormal", {63'd0, bus.out_subnormal}, {63'd0, e.v.sub});
                        chk("out_lza_corr", {63'd0, bus.out_lza_corr}, {63'd0, e.v.corr});
                        if (e.chk_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'd2);
                        if (e.v.corr) exp_cc++;
                    end
                end else begin
                    held_v = 1'b1;
                    held   = cur;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //       sum                 cnt    exp     sg    mant                oexp    z     sub   corr
        tv[0] = '{48'h0000_0100_0000, 6'd23, 10'd100, 1'b0, 48'h8000_0000_0000, 10'd77,  1'b0, 1'b0, 1'b0};
        tv[1] = '{48'h0000_0100_0000, 6'd22, 10'd100, 1'b0, 48'h8000_0000_0000, 10'd77,  1'b0, 1'b0, 1'b1};
        tv[2] = '{48'h0000_0000_0000, 6'd47, 10'd120, 1'b1, 48'h0000_0000_0000, 10'd0,   1'b1, 1'b0, 1'b0};
        tv[3] = '{48'h0000_0100_0000, 6'd23, 10'd10,  1'b0, 48'h0002_0000_0000, 10'd0,   1'b0, 1'b1, 1'b0};
        tv[4] = '{48'h8000_0000_0000, 6'd0,  10'd5,   1'b1, 48'h8000_0000_0000, 10'd5,   1'b0, 1'b0, 1'b0};
        tv[5] = '{48'h0000_0000_0001, 6'd47, 10'd0,   1'b0, 48'h0000_0000_0001, 10'd0,   1'b0, 1'b1, 1'b0};
        tv[6] = '{48'h0000_0000_0001, 6'd63, 10'd200, 1'b0, 48'h8000_0000_0000, 10'd153, 1'b0, 1'b0, 1'b0};
        tv[7] = '{48'h0000_0000_0001, 6'd46, 10'd200, 1'b1, 48'h8000_0000_0000, 10'd153, 1'b0, 1'b0, 1'b1};
        tv[8] = '{48'h0000_0100_0000, 6'd22, 10'd24,  1'b0, 48'h8000_0000_0000, 10'd1,   1'b0, 1'b0, 1'b1};
        tv[9] = '{48'h0000_0100_0000, 6'd22, 10'd23,  1'b0, 48'h4000_0000_0000, 10'd0,   1'b0, 1'b1, 1'b0};

        bus.in_valid     = 1'b0;
        bus.in_sum       = '0;
        bus.in_lza_count = '0;
        bus.in_exp       = '0;
        bus.in_sign      = 1'b0;
        bus.out_ready    = 1'b1;
        rst_n            = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_mant", {16'd0, bus.out_mant}, 64'd0);
        chk("rst_out_exp", {54'd0, bus.out_exp}, 64'd0);
        chk("rst_flags", {60'd0, bus.out_sign, bus.out_zero, bus.out_subnormal, bus.out_lza_corr}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
`ifdef FPU_NORM_CORR_CNT_EN
        chk("rst_corr_count", {48'd0, corr_count}, 64'd0);
`endif
        rst_n = 1'b1;

        // Single items, then a corrected item and the counter step
        send(tv[0], 1'b1, 1'b0);
        idle();
        drain();
        send(tv[1], 1'b1, 1'b0);
        idle();
        drain();
`ifdef FPU_NORM_CORR_CNT_EN
        chk("corr_count_after_v2", {48'd0, corr_count}, 64'(exp_cc));
`endif

        // Full-throughput stream of the remaining vectors
        for (int i = 2; i < 10; i++) send(tv[i], 1'b1, 1'b0);
        idle();
        drain();
`ifdef FPU_NORM_CORR_CNT_EN
        chk("corr_count_after_stream", {48'd0, corr_count}, 64'(exp_cc));
`endif

        // Downstream stall: third item must wait until out_ready returns
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(tv[0], 1'b0, 1'b0);
        send(tv[1], 1'b0, 1'b0);
        fork
            begin
                repeat (3) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join_none
        send(tv[3], 1'b0, 1'b1);
        idle();
        drain();

        // Reset with both stages occupied discards them
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(tv[1], 1'b0, 1'b0);
        send(tv[7], 1'b0, 1'b0);
        idle();
        #1;
        chk("full_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("midrst_out_mant", {16'd0, bus.out_mant}, 64'd0);
`ifdef FPU_NORM_CORR_CNT_EN
        chk("midrst_corr_count", {48'd0, corr_count}, 64'd0);
`endif
        sb.delete();
        exp_cc        = 0;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("post_rst_no_stale", {63'd0, bus.out_valid}, 64'd0);

        send(tv[8], 1'b1, 1'b0);
        idle();
        drain();
`ifdef FPU_NORM_CORR_CNT_EN
        chk("corr_count_post_rst", {48'd0, corr_count}, 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
